// File: rtl/ahb_lite_slave_bridge.sv
// AHB-Lite slave bridging bus transfers onto a word-addressed backend register/sensor port.
// Optional feature macro AHB_SLAVE_RDATA_REG_EN: registered HRDATA (one extra wait state per read).
module ahb_lite_slave_bridge #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
    parameter int          NUM_WORDS      = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_OUT_WIDTH = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HSEL,
    input  logic                      HREADY,
    input  logic [31:0]               HADDR,
    input  logic                      HWRITE,
    input  logic [1:0]                HTRANS,
    input  logic [2:0]                HSIZE,
    input  logic [2:0]                HBURST,
    input  logic [DATA_WIDTH-1:0]     HWDATA,
    output logic [DATA_WIDTH-1:0]     HRDATA,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [ADDR_OUT_WIDTH-1:0] be_addr,
    output logic [DATA_WIDTH-1:0]     be_wdata,
    output logic [DATA_WIDTH/8-1:0]   be_wstrb,
    output logic                      be_wen,
    output logic                      be_ren,
    input  logic [DATA_WIDTH-1:0]     be_rdata,
    input  logic                      be_wait,
    output logic [4:0]                burst_beat
);
    localparam int          STRB_W   = DATA_WIDTH / 8;
    localparam int          LANE_W   = $clog2(STRB_W);
    localparam logic [31:0] WINDOW   = 32'(NUM_WORDS * STRB_W);
    localparam logic [2:0]  MAX_SIZE = 3'(LANE_W);

    localparam logic [1:0] ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_ERR1 = 2'd2, ST_ERR2 = 2'd3;
    localparam logic [1:0] TR_SEQ = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'b000, BU_INCR = 3'b001;

    logic [1:0]                state;
    logic [ADDR_OUT_WIDTH-1:0] cap_off;
    logic [2:0]                cap_size;
    logic                      cap_write;
    logic                      burst_open;
    logic [2:0]                burst_type, burst_size;
    logic [31:0]               last_addr;
    logic [4:0]                beat_q;

    logic        accept, is_seq, err, is_wrap, complete;
    logic [31:0] offset, step, incr_addr, wrap_mask, exp_addr;
    logic [5:0]  burst_len;
    logic [STRB_W-1:0] lane_mask;

    // Address-phase decode and validation against the open burst.
    always_comb begin
        accept    = HSEL & HREADY & HTRANS[1];
        is_seq    = (HTRANS == TR_SEQ);
        offset    = HADDR - BASE_ADDRESS;
        step      = 32'd1 << burst_size;
        incr_addr = last_addr + step;
        wrap_mask = (step << ({1'b0, burst_type[2:1]} + 3'd1)) - 32'd1;
        is_wrap   = (burst_type[0] == 1'b0) && (burst_type != BU_SINGLE);
        exp_addr  = is_wrap ? ((last_addr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
        burst_len = (burst_type == BU_SINGLE) ? 6'd1 : (6'd2 << burst_type[2:1]);
        err = (HADDR < BASE_ADDRESS) || (offset >= WINDOW) || (HSIZE > MAX_SIZE)
            || ((HADDR & ((32'd1 << HSIZE) - 32'd1)) != 32'd0);
        if (is_seq) begin
            if (!burst_open)
                err = 1'b1;
            else if ((burst_type != BU_INCR) && (({1'b0, beat_q} + 6'd1) >= burst_len))
                err = 1'b1;
            else if (HADDR != exp_addr)
                err = 1'b1;
        end
    end

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < STRB_W; i++)
            lane_mask[i] = (i >= int'(cap_off[LANE_W-1:0]))
                        && (i < int'(cap_off[LANE_W-1:0]) + (1 << cap_size));
    end

`ifdef AHB_SLAVE_RDATA_REG_EN
    logic                  rd_hold;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Reads take one extra cycle: capture be_rdata, then complete from the flop.
    assign complete = cap_write ? !be_wait : rd_hold;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_hold <= 1'b0;
            rdata_q <= '0;
        end else if (state == ST_DATA && !cap_write && !rd_hold) begin
            if (!be_wait) begin
                rd_hold <= 1'b1;
                rdata_q <= be_rdata;
            end
        end else begin
            rd_hold <= 1'b0;
        end
    end
`else
    assign complete = !be_wait;
`endif

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        be_wen    = 1'b0;
        be_ren    = 1'b0;
        be_wstrb  = '0;
        HRDATA    = '0;
        case (state)
            ST_DATA: begin
                HREADYOUT = complete;
                be_wen    = cap_write;
`ifdef AHB_SLAVE_RDATA_REG_EN
                be_ren    = !cap_write && !rd_hold;
                be_wstrb  = rd_hold ? '0 : lane_mask;
                HRDATA    = rd_hold ? rdata_q : '0;
`else
                be_ren    = !cap_write;
                be_wstrb  = lane_mask;
                HRDATA    = be_rdata;
`endif
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    assign be_addr    = cap_off;
    assign be_wdata   = HWDATA;
    assign burst_beat = beat_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            cap_off    <= '0;
            cap_size   <= '0;
            cap_write  <= 1'b0;
            burst_open <= 1'b0;
            burst_type <= '0;
            burst_size <= '0;
            last_addr  <= '0;
            beat_q     <= '0;
        end else if (accept) begin
            state <= err ? ST_ERR1 : ST_DATA;
            if (!err) begin
                cap_off   <= offset[ADDR_OUT_WIDTH-1:0];
                cap_size  <= HSIZE;
                cap_write <= HWRITE;
                last_addr <= HADDR;
                if (is_seq) begin
                    if (beat_q != 5'd31) beat_q <= beat_q + 5'd1;
                end else begin
                    burst_open <= 1'b1;
                    burst_type <= HBURST;
                    burst_size <= HSIZE;
                    beat_q     <= '0;
                end
            end else if (!is_seq) begin
                // A rejected NONSEQ leaves no burst to continue.
                burst_open <= 1'b0;
                beat_q     <= '0;
            end
        end else begin
            case (state)
                ST_DATA: if (complete) state <= ST_IDLE;
                ST_ERR1: state <= ST_ERR2;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_lite_slave_bridge.sv
// Self-checking bench for ahb_lite_slave_bridge: directed plan steps plus randomized single transfers
// checked against a byte-level reference memory.
module tb_ahb_lite_slave_bridge;
    localparam int NW = 32;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000, B_WRAP4 = 3'b010, B_INCR4 = 3'b011, B_INCR8 = 3'b101;

    logic        HCLK = 1'b0;
    logic        HRESET, HSEL, HREADY, HWRITE;
    logic [31:0] HADDR, HWDATA, HRDATA, be_wdata, be_rdata;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic        HREADYOUT, HRESP, be_wen, be_ren, be_wait;
    logic [15:0] be_addr;
    logic [3:0]  be_wstrb;
    logic [4:0]  burst_beat;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ahb_lite_slave_bridge #(
        .BASE_ADDRESS(32'h0), .NUM_WORDS(NW), .DATA_WIDTH(32), .ADDR_OUT_WIDTH(16)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .be_addr(be_addr),
        .be_wdata(be_wdata), .be_wstrb(be_wstrb), .be_wen(be_wen), .be_ren(be_ren),
        .be_rdata(be_rdata), .be_wait(be_wait), .burst_beat(burst_beat)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Backend store: commits a write on the cycle the backend is not stalling.
    logic [31:0] bmem [NW];
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < NW; i++) bmem[i] <= init_word(i);
        end else if (be_wen && !be_wait) begin
            for (int b = 0; b < 4; b++)
                if (be_wstrb[b]) bmem[be_addr[6:2]][8*b +: 8] <= be_wdata[8*b +: 8];
        end
    end
    assign be_rdata = bmem[be_addr[6:2]];

    logic [31:0] refmem [NW];
    int vectors = 0, miscompares = 0;

    task automatic ref_init();
        for (int i = 0; i < NW; i++) refmem[i] = init_word(i);
    endtask

    function automatic bit model_err(logic [31:0] a, logic [2:0] sz);
        return (a >= 32'(NW * 4)) || (sz > 3'd2) || ((a % (32'd1 << sz)) != 32'd0);
    endfunction

    function automatic logic [3:0] model_lanes(logic [31:0] a, logic [2:0] sz);
        logic [7:0] m;
        m = 8'(((1 << (1 << sz)) - 1) << (a % 4));
        return m[3:0];
    endfunction

    task automatic ref_write(logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        logic [3:0] ln;
        ln = model_lanes(a, sz);
        for (int b = 0; b < 4; b++)
            if (ln[b]) refmem[a[6:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ap(logic sel, logic [1:0] tr, logic wr, logic [31:0] a, logic [2:0] sz, logic [2:0] bu);
        HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; HSIZE = sz; HBURST = bu;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // One transfer from an idle slave: address phase, then data phase with `gap` on the address bus.
    task automatic xfer(string tag, logic [1:0] tr, logic wr, logic [31:0] a, logic [2:0] sz,
                        logic [2:0] bu, logic [1:0] gap, logic [31:0] wd, int nwait,
                        bit exp_err, int exp_beat);
        ap(1'b1, tr, wr, a, sz, bu);
        @(negedge HCLK);
        chk({tag, ".idle"}, {28'd0, HREADYOUT, HRESP, be_wen, be_ren}, 32'b1000);
        tick();
        ap(1'b1, gap, wr, a, sz, bu);
        HWDATA = wd;
        if (exp_err) begin
            @(negedge HCLK);
            chk({tag, ".err1"}, {28'd0, HREADYOUT, HRESP, be_wen, be_ren}, 32'b0100);
            tick();
            @(negedge HCLK);
            chk({tag, ".err2"}, {28'd0, HREADYOUT, HRESP, be_wen, be_ren}, 32'b1100);
            tick();
        end else begin
            for (int k = 0; k <= nwait; k++) begin
                be_wait = (k < nwait);
                @(negedge HCLK);
                chk({tag, ".rdy"}, {30'd0, HREADYOUT, HRESP}, {30'd0, k == nwait, 1'b0});
                chk({tag, ".en"}, {30'd0, be_wen, be_ren}, {30'd0, wr, !wr});
                chk({tag, ".addr"}, {16'd0, be_addr}, {16'd0, a[15:0]});
                chk({tag, ".strb"}, {28'd0, be_wstrb}, {28'd0, model_lanes(a, sz)});
                chk({tag, ".beat"}, {27'd0, burst_beat}, 32'(exp_beat));
                if (wr) chk({tag, ".wdata"}, be_wdata, wd);
                else if (k == nwait) chk({tag, ".rdata"}, HRDATA, refmem[a[6:2]]);
                tick();
            end
            be_wait = 1'b0;
            if (wr) ref_write(a, sz, wd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        logic        wr;
        HRESET = 1'b1; be_wait = 1'b0; HWDATA = '0;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, B_SINGLE);
        tick(); tick();
        HRESET = 1'b0;
        ref_init();
        @(negedge HCLK);
        chk("reset.ctl", {28'd0, HREADYOUT, HRESP, be_wen, be_ren}, 32'b1000);
        chk("reset.addr", {16'd0, be_addr}, 32'd0);
        chk("reset.strb", {28'd0, be_wstrb}, 32'd0);
        chk("reset.beat", {27'd0, burst_beat}, 32'd0);
        tick();

        // Plan 1-2: word write, halfword write, misaligned word write
        xfer("t1.word", T_NSEQ, 1'b1, 32'h10, 3'd2, B_SINGLE, T_IDLE, 32'hDEADBEEF, 0, 1'b0, 0);
        xfer("t2.half", T_NSEQ, 1'b1, 32'h12, 3'd1, B_SINGLE, T_IDLE, 32'h1234_5678, 0, 1'b0, 0);
        xfer("t2.misal", T_NSEQ, 1'b1, 32'h02, 3'd2, B_SINGLE, T_IDLE, 32'h0BAD_0BAD, 0, 1'b1, 0);

        // Plan 3: out-of-window read, next read accepted during ERR2
        ap(1'b1, T_NSEQ, 1'b0, 32'h80, 3'd2, B_SINGLE);
        tick();
        ap(1'b1, T_NSEQ, 1'b0, 32'h04, 3'd2, B_SINGLE);
        @(negedge HCLK);
        chk("t3.err1", {29'd0, HREADYOUT, HRESP, be_ren}, 32'b010);
        tick();
        @(negedge HCLK);
        chk("t3.err2", {29'd0, HREADYOUT, HRESP, be_ren}, 32'b110);
        tick();
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, B_SINGLE);
        @(negedge HCLK);
        chk("t3.data", {29'd0, HREADYOUT, HRESP, be_ren}, 32'b101);
        chk("t3.addr", {16'd0, be_addr}, 32'h4);
        chk("t3.rdata", HRDATA, refmem[1]);
        tick();

        // Plan 4: pipelined INCR4 read with a BUSY and two wait states on beat 2
        ap(1'b1, T_NSEQ, 1'b0, 32'h20, 3'd2, B_INCR4);
        tick();
        ap(1'b1, T_SEQ, 1'b0, 32'h24, 3'd2, B_INCR4);
        @(negedge HCLK);
        chk("t4.b0.rdy", {31'd0, HREADYOUT}, 32'd1);
        chk("t4.b0.addr", {16'd0, be_addr}, 32'h20);
        chk("t4.b0.beat", {27'd0, burst_beat}, 32'd0);
        chk("t4.b0.rdata", HRDATA, refmem[8]);
        tick();
        ap(1'b1, T_BUSY, 1'b0, 32'h28, 3'd2, B_INCR4);
        @(negedge HCLK);
        chk("t4.b1.addr", {16'd0, be_addr}, 32'h24);
        chk("t4.b1.beat", {27'd0, burst_beat}, 32'd1);
        chk("t4.b1.rdata", HRDATA, refmem[9]);
        tick();
        ap(1'b1, T_SEQ, 1'b0, 32'h28, 3'd2, B_INCR4);
        @(negedge HCLK);
        chk("t4.busy", {26'd0, HREADYOUT, be_ren, burst_beat}, {26'd0, 1'b1, 1'b0, 5'd1});
        tick();
        ap(1'b1, T_SEQ, 1'b0, 32'h2C, 3'd2, B_INCR4);
        for (int w = 0; w <= 2; w++) begin
            be_wait = (w < 2);
            @(negedge HCLK);
            chk("t4.b2.rdy", {31'd0, HREADYOUT}, {31'd0, w == 2});
            chk("t4.b2.hold", {10'd0, be_ren, be_addr, burst_beat}, {10'd0, 1'b1, 16'h28, 5'd2});
            if (w == 2) chk("t4.b2.rdata", HRDATA, refmem[10]);
            tick();
        end
        be_wait = 1'b0;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, B_SINGLE);
        @(negedge HCLK);
        chk("t4.b3", {10'd0, HREADYOUT, be_addr, burst_beat}, {10'd0, 1'b1, 16'h2C, 5'd3});
        chk("t4.b3.rdata", HRDATA, refmem[11]);
        tick();
        xfer("t4.over", T_SEQ, 1'b0, 32'h30, 3'd2, B_INCR4, T_IDLE, 32'h0, 0, 1'b1, 0);

        // Plan 5: WRAP4 from 0x38, then a wrong third-beat address
        xfer("t5.b0", T_NSEQ, 1'b1, 32'h38, 3'd2, B_WRAP4, T_BUSY, $urandom, 0, 1'b0, 0);
        xfer("t5.b1", T_SEQ,  1'b1, 32'h3C, 3'd2, B_WRAP4, T_BUSY, $urandom, 0, 1'b0, 1);
        xfer("t5.b2", T_SEQ,  1'b1, 32'h30, 3'd2, B_WRAP4, T_BUSY, $urandom, 1, 1'b0, 2);
        xfer("t5.b3", T_SEQ,  1'b1, 32'h34, 3'd2, B_WRAP4, T_IDLE, $urandom, 0, 1'b0, 3);
        xfer("t5r.b0", T_NSEQ, 1'b0, 32'h38, 3'd2, B_WRAP4, T_BUSY, 32'h0, 0, 1'b0, 0);
        xfer("t5r.b1", T_SEQ,  1'b0, 32'h3C, 3'd2, B_WRAP4, T_BUSY, 32'h0, 0, 1'b0, 1);
        xfer("t5r.b2", T_SEQ,  1'b0, 32'h40, 3'd2, B_WRAP4, T_IDLE, 32'h0, 0, 1'b1, 0);

        // Plan 6: reset during beat 1 of INCR8, then an orphan SEQ
        ap(1'b1, T_NSEQ, 1'b1, 32'h40, 3'd2, B_INCR8);
        tick();
        ap(1'b1, T_SEQ, 1'b1, 32'h44, 3'd2, B_INCR8);
        HWDATA = 32'h1111_2222;
        tick();
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, B_SINGLE);
        be_wait = 1'b1;
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("t6.b1.beat", {27'd0, burst_beat}, 32'd1);
        tick();
        HRESET = 1'b0;
        be_wait = 1'b0;
        ref_init();
        @(negedge HCLK);
        chk("t6.rst.ctl", {28'd0, HREADYOUT, HRESP, be_wen, be_ren}, 32'b1000);
        chk("t6.rst.strb", {23'd0, be_wstrb, burst_beat}, 32'd0);
        chk("t6.rst.addr", {16'd0, be_addr}, 32'd0);
        tick();
        xfer("t6.seq", T_SEQ, 1'b1, 32'h48, 3'd2, B_INCR8, T_IDLE, 32'h0, 0, 1'b1, 0);

        // Randomized single transfers against the reference memory
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 32'h9F));
            if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            xfer("rnd", T_NSEQ, wr, a, sz, B_SINGLE, T_IDLE, $urandom,
                 int'($urandom_range(0, 2)), model_err(a, sz), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ahb_lite_slave_bridge.md
Name: ahb_lite_slave_bridge

Overview:
Parametrised AHB-Lite slave that bridges bus transfers onto a simple word-addressed backend register/sensor port.
- Properly pipelined: address phase and data phase are separated.
- Handles byte/halfword/word (and dword at 64-bit) sizes with byte strobes.
- Tracks and validates INCR/WRAP bursts.
- Issues the two-cycle AHB ERROR response.
- Sits between the AHB-Lite interconnect and the control/sensor block.

Parameters:
- BASE_ADDRESS, 32'h0000_0000: first byte address decoded by this slave.
- NUM_WORDS, 32: number of DATA_WIDTH-wide backend locations. Decoded window = NUM_WORDS*(DATA_WIDTH/8) bytes.
- DATA_WIDTH, 32: bus data width; legal values 32 or 64.
- ADDR_OUT_WIDTH, 16: width of backend byte offset.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  synchronous active-high reset.
- HSEL  in  1  slave select.
- HREADY  in  1  global bus ready; address phase is sampled only when high.
- HADDR  in  32  byte address.
- HWRITE  in  1  1=write.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type.
- HWDATA  in  DATA_WIDTH  write data (data phase).
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- be_addr  out  ADDR_OUT_WIDTH  byte offset from BASE_ADDRESS of the data-phase transfer.
- be_wdata  out  DATA_WIDTH  write data to backend.
- be_wstrb  out  DATA_WIDTH/8  byte lane enables.
- be_wen  out  1  write request.
- be_ren  out  1  read request.
- be_rdata  in  DATA_WIDTH  backend read data.
- be_wait  in  1  backend stall.
- burst_beat  out  5  beat index of the current data phase.

Behaviour:
Reset:
- HRESET is sampled on rising HCLK only.
- Reset forces state=IDLE, HREADYOUT=1, HRESP=0, be_wen=0, be_ren=0, be_addr=0, be_wstrb=0, burst_beat=0, and clears all captured address-phase registers.
- Reset asserted mid-transfer abandons the transfer. No backend strobe is issued in the cycle after reset.

Address-phase acceptance:
- A transfer is accepted when HSEL & HREADY & HTRANS in {NONSEQ,SEQ}.
- IDLE/BUSY (or HSEL=0) with HREADY=1 is not a transfer. The next data phase gives a zero-wait OKAY. burst_beat holds on BUSY.

Error checks on an accepted transfer (any one → error):
- HADDR < BASE_ADDRESS, or offset >= window.
- HSIZE > log2(DATA_WIDTH/8).
- Address not aligned to HSIZE.
- SEQ with no open burst.
- SEQ beyond burst length for INCR4/8/16 or WRAP4/8/16.
- SEQ address ≠ expected address. Expected = previous+2^HSIZE for INCR*; wraps on a 2^HSIZE*beats boundary for WRAP*.

Burst tracking:
- NONSEQ sets burst_beat=0 and latches HBURST/HSIZE.
- Each accepted SEQ increments burst_beat. 5-bit saturating; undefined-length INCR saturates at 31 and checks no length.

State machine (IDLE, DATA, ERR1, ERR2):
- IDLE→DATA on a valid accepted transfer; IDLE→ERR1 on an erroneous one.
- DATA:
  - be_addr = captured offset.
  - be_wstrb = lanes selected by captured HSIZE and offset low bits.
  - be_ren = captured read; be_wen = captured write; be_wdata = HWDATA.
  - HREADYOUT = ~be_wait; HRESP=0.
  - Stays in DATA while be_wait=1; strobes are held stable.
  - On completion (be_wait=0): a simultaneously accepted new transfer gives back-to-back DATA or ERR1; otherwise →IDLE.
- ERR1: HREADYOUT=0, HRESP=1, no strobes; →ERR2.
- ERR2: HREADYOUT=1, HRESP=1. A transfer accepted here is processed normally (→DATA/ERR1); else →IDLE.

Other rules:
- The erroneous transfer never reaches the backend. The burst remains open only if the master continues with SEQ; NONSEQ restarts it.
- HRDATA = be_rdata in DATA, 0 otherwise.

Optional Feature:
AHB_SLAVE_RDATA_REG_EN:
- When defined: HRDATA is registered. Every read data phase inserts exactly one additional HREADYOUT=0 cycle after be_wait falls, and HRDATA is valid from a flop on the completing cycle. Writes are unaffected.
- When undefined: HRDATA is combinational from be_rdata; reads complete in the first cycle with be_wait=0.

Test Plan:
1. DATA_WIDTH=32, BASE=0. NONSEQ write 0x10, HSIZE=2, HWDATA=0xDEADBEEF, be_wait=0 → next cycle be_wen=1, be_addr=0x0010, be_wstrb=4'b1111, be_wdata=0xDEADBEEF, HREADYOUT=1, HRESP=0.
2. Halfword write 0x12 → be_wstrb=4'b1100. Word write at 0x02 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); be_wen stays 0.
3. Read at 0x80 (out of window) → ERR1, ERR2, be_ren never 1. Then NONSEQ read 0x04 accepted in ERR2 → DATA with be_ren=1, be_addr=0x0004.
4. INCR4 read 0x20, 0x24, 0x28, 0x2C; be_wait=1 for 2 cycles on beat 2 → HREADYOUT low exactly 2 cycles, burst_beat 0,1,2,3, HRDATA=be_rdata on each completing cycle, one BUSY inserted leaves burst_beat unchanged.
5. WRAP4 from 0x38: 0x3C, 0x30, 0x34 → all OKAY. Repeat with third beat SEQ 0x40 → error response on that beat only.
6. HRESET asserted during beat 1 of INCR8 → next cycle IDLE, HREADYOUT=1, HRESP=0, strobes 0, burst_beat=0. A subsequent SEQ → error.
